ch_desel: RTL and testbench

CH_DESEL -- requirements
Module: ch_desel

---
 rtl/ch_desel_pkg.sv | 9 +
 rtl/ch_idx_ctr.sv | 40 ++++
 rtl/ch_desel.sv | 88 ++++++++
 tb/tb_ch_desel.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ch_desel_pkg.sv
// Shared definitions for the channel select / deselect blocks.
package ch_desel_pkg;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [7:0] ERR_SAT = 8'hFF;
endpackage

// File: rtl/ch_idx_ctr.sv
// Wrapping channel-index counter: load sets the limit and restarts at 1 (or 0
// for a single-channel frame); advance wraps to 0 after the latched limit.
module ch_idx_ctr #(
    parameter int CH_W = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            adv_i,
    input  logic [CH_W-1:0] lim_i,
    output logic [CH_W-1:0] idx_o,
    output logic [CH_W-1:0] max_o
);
    logic [CH_W-1:0] idx_q, idx_d;
    logic [CH_W-1:0] max_q, max_d;

    always_comb begin
        idx_d = idx_q;
        max_d = max_q;
        if (load_i) begin
            max_d = lim_i;
            idx_d = (lim_i == '0) ? '0 : CH_W'(1);
        end else if (adv_i) begin
            idx_d = (idx_q == max_q) ? '0 : idx_q + CH_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= '0;
            max_q <= '0;
        end else begin
            idx_q <= idx_d;
            max_q <= max_d;
        end
    end

    assign idx_o = idx_q;
    assign max_o = max_q;
endmodule

// File: rtl/ch_desel.sv
// Channel de-interleaver: tags each strobed sample with its channel index,
// locking on sync and flagging syncs that arrive mid-frame.
module ch_desel
    import ch_desel_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CH_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             strobe,
    input  logic             sync,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CH_W-1:0]  channels,
    output logic [WIDTH-1:0] data_out,
    output logic [CH_W-1:0]  ch_out,
    output logic             valid_out,
    output logic             frame_done,
    output logic             sync_err,
    output logic [7:0]       err_count
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [CH_W-1:0]  ch_q;
    logic             valid_q, fd_q, serr_q;
    logic [7:0]       errc_q;

    logic             accept, is_ch0, load, adv, misalign, fd_d;
    logic [CH_W-1:0]  idx, ch_max, ch_d;

    ch_idx_ctr #(.CH_W(CH_W)) u_idx (
        .clk_i  (clk),
        .rst_i  (reset),
        .load_i (load),
        .adv_i  (adv),
        .lim_i  (channels),
        .idx_o  (idx),
        .max_o  (ch_max)
    );

    // Any channel-0 emission restarts the frame and re-latches the limit,
    // so a new channel count only takes effect at a frame boundary.
    always_comb begin
        accept   = enable && strobe && (state_q == ST_RUN || sync);
        is_ch0   = (state_q == ST_IDLE) || sync || (idx == '0);
        load     = accept && is_ch0;
        adv      = accept && !is_ch0;
        misalign = accept && (state_q == ST_RUN) && sync && (idx != '0);
        ch_d     = is_ch0 ? '0 : idx;
        fd_d     = is_ch0 ? (channels == '0) : (idx == ch_max);
        state_d  = state_q;
        if (!enable)
            state_d = ST_IDLE;
        else if (accept)
            state_d = ST_RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            fd_q    <= 1'b0;
            serr_q  <= 1'b0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= accept;
            fd_q    <= accept && fd_d;
            serr_q  <= misalign;
            if (accept) begin
                data_q <= data_in;
                ch_q   <= ch_d;
            end
            if (misalign && errc_q != ERR_SAT)
                errc_q <= errc_q + 8'd1;
        end
    end

    assign data_out   = data_q;
    assign ch_out     = ch_q;
    assign valid_out  = valid_q;
    assign frame_done = fd_q;
    assign sync_err   = serr_q;
    assign err_count  = errc_q;
endmodule

// File: tb/tb_ch_desel.sv
// Scoreboard bench for ch_desel: stimulus pushes expected outputs, a negedge
// monitor pops and compares them against each valid_out pulse.
module tb_ch_desel;
    logic        clk = 1'b0;
    logic        reset, enable, strobe, sync;
    logic [15:0] data_in;
    logic [2:0]  channels;
    logic [15:0] data_out;
    logic [2:0]  ch_out;
    logic        valid_out, frame_done, sync_err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  ch;
        logic        fd;
        logic        se;
        int          cyc;
    } exp_t;
    exp_t q[$];

    ch_desel #(.WIDTH(16), .CH_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .strobe     (strobe),
        .sync       (sync),
        .data_in    (data_in),
        .channels   (channels),
        .data_out   (data_out),
        .ch_out     (ch_out),
        .valid_out  (valid_out),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Monitor: every valid_out must match the oldest expectation, one clock late.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid_out) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid data %0h ch %0d", data_out, ch_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    checks++;
                    if ({data_out, ch_out, frame_done, sync_err} !== {e.d, e.ch, e.fd, e.se} ||
                        cyc != e.cyc + 1) begin
                        errors++;
                        $display("FAIL sample d/ch/fd/se/cyc actual %0h/%0d/%0b/%0b/%0d required %0h/%0d/%0b/%0b/%0d",
                                 data_out, ch_out, frame_done, sync_err, cyc,
                                 e.d, e.ch, e.fd, e.se, e.cyc + 1);
                    end
                end
            end else begin
                if (frame_done || sync_err) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_pulse fd %0b se %0b required 0 0", frame_done, sync_err);
                end
                if (q.size() > 0 && cyc > q[0].cyc + 1) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_output data actual none required %0h", q[0].d);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic s, input logic emit,
                        input logic [2:0] ch, input logic fd, input logic se, input int gap);
        exp_t e;
        data_in = d;
        sync    = s;
        strobe  = 1'b1;
        if (emit) begin
            e.d = d; e.ch = ch; e.fd = fd; e.se = se; e.cyc = cyc;
            q.push_back(e);
        end
        tick();
        strobe = 1'b0;
        sync   = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_out"}, 32'(data_out), 32'h0);
        chk({tag, "_ch_out"}, 32'(ch_out), 32'h0);
        chk({tag, "_pulses"}, {29'h0, valid_out, frame_done, sync_err}, 32'h0);
        chk({tag, "_err_count"}, 32'(err_count), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; strobe = 1'b0; sync = 1'b0;
        data_in = '0; channels = 3'd3;
        #1;
        chk_reset_outputs("reset");
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Unsynchronised samples are dropped until the first sync.
        send(16'h0001, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1);
        send(16'h0002, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1);
        send(16'h0003, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1);
        send(16'h0020, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1);
        send(16'h0021, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1);
        send(16'h0022, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1);
        send(16'h0023, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1);
        chk("err_after_lock", 32'(err_count), 32'd0);

        // Two 4-channel frames, strobe every 64 clocks, sync only on the first.
        for (int i = 0; i < 8; i++)
            send(16'h0010 + 16'(i), (i == 0), 1'b1, 3'(i % 4), (i % 4 == 3), 1'b0, 63);

        // Sync on the third sample: forced back to channel 0.
        send(16'h0030, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 2);
        send(16'h0031, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 2);
        send(16'h0032, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 2);
        chk("err_after_misalign", 32'(err_count), 32'd1);
        send(16'h0033, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 2);
        send(16'h0034, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 2);
        send(16'h0035, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 2);

        // Channel count change mid-frame applies from the next frame.
        send(16'h0040, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1);
        send(16'h0041, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1);
        channels = 3'd1;
        send(16'h0042, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1);
        send(16'h0043, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1);
        send(16'h0044, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1);
        send(16'h0045, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1);
        send(16'h0046, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1);
        send(16'h0047, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1);

        // Saturation: every sync below lands at index 1.
        send(16'h0080, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 300; i++)
            send(16'h0100 + 16'(i), 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 0);
        tick();
        chk("err_saturated", 32'(err_count), 32'd255);

        // Single-channel frame: misaligned sync still reports frame_done.
        channels = 3'd0;
        send(16'h0070, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1);
        send(16'h0071, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1);
        chk("err_hold_at_sat", 32'(err_count), 32'd255);

        // Disable drops to IDLE; the block then waits for a fresh sync.
        enable = 1'b0;
        send(16'h0072, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1);
        enable = 1'b1;
        send(16'h0073, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1);
        chk("err_hold_disable", 32'(err_count), 32'd255);
        send(16'h0074, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1);

        // Reset mid-frame at channel 2.
        channels = 3'd3;
        send(16'h0050, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 0);
        send(16'h0051, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 0);
        send(16'h0052, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1);
        chk("held_data_before_reset", 32'(data_out), 32'h0052);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        tick();
        reset = 1'b0;
        tick();
        send(16'h005F, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1);
        send(16'h0060, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 0);
        send(16'h0061, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 0);
        send(16'h0062, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 0);
        send(16'h0063, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 0);
        send(16'h0064, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 0);
        repeat (4) tick();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
